// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin write arbiter that lets NUM_REQ producers share the single write
//   port of a 16-entry synchronous FIFO. One producer at a time is granted for a
//   burst of at most MAX_BURST words; its data is steered onto the FIFO write
//   pins. The FIFO full flag back-pressures whoever currently holds the grant.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   req        per-producer write request, data valid while high
//   req_data   producer i data in bits [i*DATA_W +: DATA_W]
//   ack        one-hot acceptance, combinational
//   fifo_wr    FIFO write strobe, combinational
//   fifo_din   FIFO write data, combinational (zero when not writing)
//   fifo_full  FIFO full flag
//   grant_id   registered index of the current/last grantee
//   busy       registered, high while a grant is held
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    localparam int IDW      = $clog2(NUM_REQ),
    localparam int BCW      = $clog2(MAX_BURST + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      fifo_wr,
    output logic [DATA_W-1:0]         fifo_din,
    input  logic                      fifo_full,
    output logic [IDW-1:0]            grant_id,
    output logic                      busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_grant_id;
    logic [BCW-1:0]   r_burst_cnt;

    state_t           w_state_next;
    logic [IDW-1:0]   w_rr_next;
    logic [IDW-1:0]   w_gid_next;
    logic [BCW-1:0]   w_burst_next;
    logic [IDW-1:0]   w_pick;
    logic [IDW-1:0]   w_gid_inc;
    logic [NUM_REQ-1:0] w_ack;
    logic             w_wr;
    logic [DATA_W-1:0] w_din;

    // Scan downward so the requester closest to ptr (smallest offset) is the
    // last one written and therefore wins. Indices wrap explicitly so that a
    // non-power-of-two NUM_REQ never selects a nonexistent requester.
    function automatic logic [IDW-1:0] pickNext(input logic [NUM_REQ-1:0] reqVec,
                                                input logic [IDW-1:0]     ptr);
        logic [IDW-1:0] sel;
        int             idx;
        sel = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (reqVec[idx]) begin
                sel = IDW'(idx);
            end
        end
        return sel;
    endfunction

    assign w_pick    = pickNext(req, r_rr_ptr);
    assign w_gid_inc = (r_grant_id == IDW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_rr_ptr    <= w_rr_next;
            r_grant_id  <= w_gid_next;
            r_burst_cnt <= w_burst_next;
        end
    end

    // In GRANT a word moves only when the grantee is requesting and the FIFO
    // has room; a stall under full holds everything, with no timeout. Ending
    // a grant parks rr_ptr just past the grantee so it becomes lowest priority.
    always_comb begin
        w_state_next = r_state;
        w_rr_next    = r_rr_ptr;
        w_gid_next   = r_grant_id;
        w_burst_next = r_burst_cnt;
        w_ack        = '0;
        w_wr         = 1'b0;
        w_din        = '0;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_gid_next   = w_pick;
                    w_burst_next = '0;
                    w_state_next = GRANT;
                end
            end
            GRANT: begin
                if (!req[r_grant_id]) begin
                    w_state_next = IDLE;
                    w_rr_next    = w_gid_inc;
                    w_burst_next = '0;
                end else if (!fifo_full) begin
                    w_wr              = 1'b1;
                    w_ack[r_grant_id] = 1'b1;
                    w_din             = req_data[r_grant_id*DATA_W +: DATA_W];
                    if (r_burst_cnt == BCW'(MAX_BURST - 1)) begin
                        w_state_next = IDLE;
                        w_rr_next    = w_gid_inc;
                        w_burst_next = '0;
                    end else begin
                        w_burst_next = r_burst_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign ack      = w_ack;
    assign fifo_wr  = w_wr;
    assign fifo_din = w_din;
    assign grant_id = r_grant_id;
    assign busy     = (r_state == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter. A 4-requester instance is driven
//   against a small FIFO occupancy model; a 3-requester instance covers the
//   non-power-of-two rotation. Expected values are hand-computed per cycle.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] reqData;
    logic [3:0]  ack;
    logic        fifoWr;
    logic [7:0]  fifoDin;
    logic        fifoFull;
    logic [1:0]  grantId;
    logic        busy;
    logic        fifoRd;
    logic [4:0]  fifoCount = 5'd0;

    logic [2:0]  req6;
    logic [23:0] reqData6;
    logic [2:0]  ack6;
    logic        wr6;
    logic [7:0]  din6;
    logic        full6;
    logic [1:0]  gid6;
    logic        busy6;

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(reqData), .ack(ack),
        .fifo_wr(fifoWr), .fifo_din(fifoDin), .fifo_full(fifoFull),
        .grant_id(grantId), .busy(busy)
    );

    fifo_wr_arbiter #(.NUM_REQ(3), .DATA_W(8), .MAX_BURST(4)) dut6 (
        .clk(clk), .rst(rst), .req(req6), .req_data(reqData6), .ack(ack6),
        .fifo_wr(wr6), .fifo_din(din6), .fifo_full(full6),
        .grant_id(gid6), .busy(busy6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Occupancy model of the 16-entry FIFO the arbiter writes into.
    assign fifoFull = (fifoCount == 5'd16);
    always @(posedge clk) begin
        fifoCount <= fifoCount + {4'd0, fifoWr} - {4'd0, (fifoRd && fifoCount != 5'd0)};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d, input logic rd);
        req     = r;
        reqData = d;
        fifoRd  = rd;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] eAck, input logic eWr,
                               input logic [7:0] eDin, input logic eBusy, input logic [1:0] eGid);
        checks++;
        assert (ack === eAck) else begin
            errors++;
            $error("FAIL %s ack actual=%b required=%b", tag, ack, eAck);
        end
        checks++;
        assert (fifoWr === eWr) else begin
            errors++;
            $error("FAIL %s fifo_wr actual=%b required=%b", tag, fifoWr, eWr);
        end
        checks++;
        assert (fifoDin === eDin) else begin
            errors++;
            $error("FAIL %s fifo_din actual=%h required=%h", tag, fifoDin, eDin);
        end
        checks++;
        assert (busy === eBusy) else begin
            errors++;
            $error("FAIL %s busy actual=%b required=%b", tag, busy, eBusy);
        end
        checks++;
        assert (grantId === eGid) else begin
            errors++;
            $error("FAIL %s grant_id actual=%0d required=%0d", tag, grantId, eGid);
        end
    endtask

    task automatic drainFifo();
        applyStimulus(4'b0000, 32'h0, 1'b1);
        repeat (20) tick();
        fifoRd = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(4'b0000, 32'h0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [7:0] t2Bytes [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    int         t2Order [5] = '{0, 1, 2, 3, 0};
    int         t6Order [4] = '{0, 1, 2, 0};

    initial begin
        int prevGid;
        rst      = 1'b1;
        req      = '0;
        reqData  = '0;
        fifoRd   = 1'b0;
        req6     = '0;
        reqData6 = '0;
        full6    = 1'b0;
        tick();
        tick();

        // Reset state, still holding rst.
        checkOutput("reset", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        rst = 1'b0;

        // Test 1: lone requester 2, data 0x11..0x16.
        applyStimulus(4'b0100, 32'h0011_0000, 1'b0);
        checkOutput("t1 bubble", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        tick();
        for (int w = 0; w < 4; w++) begin
            applyStimulus(4'b0100, {8'h00, 8'(8'h11 + w), 16'h0000}, 1'b0);
            checkOutput("t1 burst", 4'b0100, 1'b1, 8'(8'h11 + w), 1'b1, 2'd2);
            tick();
        end
        applyStimulus(4'b0100, 32'h0015_0000, 1'b0);
        checkOutput("t1 rotate idle", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd2);
        tick();
        applyStimulus(4'b0100, 32'h0015_0000, 1'b0);
        checkOutput("t1 word5", 4'b0100, 1'b1, 8'h15, 1'b1, 2'd2);
        tick();
        applyStimulus(4'b0100, 32'h0016_0000, 1'b0);
        checkOutput("t1 word6", 4'b0100, 1'b1, 8'h16, 1'b1, 2'd2);
        tick();
        applyStimulus(4'b0000, 32'h0, 1'b0);
        checkOutput("t1 release", 4'b0000, 1'b0, 8'h00, 1'b1, 2'd2);
        tick();
        applyStimulus(4'b0000, 32'h0, 1'b0);
        checkOutput("t1 idle", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd2);
        tick();
        drainFifo();
        doReset();

        // Test 2: all four requesting, rotation 0,1,2,3,0 in 4-word blocks.
        prevGid = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b1111, 32'hD3C2_B1A0, 1'b1);
            checkOutput("t2 bubble", 4'b0000, 1'b0, 8'h00, 1'b0, 2'(prevGid));
            tick();
            for (int w = 0; w < 4; w++) begin
                applyStimulus(4'b1111, 32'hD3C2_B1A0, 1'b1);
                checkOutput("t2 burst", 4'(1 << t2Order[i]), 1'b1, t2Bytes[t2Order[i]],
                            1'b1, 2'(t2Order[i]));
                tick();
            end
            prevGid = t2Order[i];
        end
        drainFifo();
        doReset();

        // Test 3: requester 1 fills the FIFO, then one read frees one slot.
        for (int b = 0; b < 4; b++) begin
            applyStimulus(4'b0010, 32'h0000_4000, 1'b0);
            checkOutput("t3 bubble", 4'b0000, 1'b0, 8'h00, 1'b0, (b == 0) ? 2'd0 : 2'd1);
            tick();
            for (int w = 0; w < 4; w++) begin
                applyStimulus(4'b0010, 32'h0000_4000, 1'b0);
                checkOutput("t3 fill", 4'b0010, 1'b1, 8'h40, 1'b1, 2'd1);
                tick();
            end
        end
        applyStimulus(4'b0010, 32'h0000_4000, 1'b0);
        checkOutput("t3 bubble full", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd1);
        tick();
        for (int s = 0; s < 2; s++) begin
            applyStimulus(4'b0010, 32'h0000_4000, 1'b0);
            checkOutput("t3 stall", 4'b0000, 1'b0, 8'h00, 1'b1, 2'd1);
            tick();
        end
        applyStimulus(4'b0010, 32'h0000_4000, 1'b1);
        checkOutput("t3 stall on read", 4'b0000, 1'b0, 8'h00, 1'b1, 2'd1);
        tick();
        applyStimulus(4'b0010, 32'h0000_4000, 1'b0);
        checkOutput("t3 one write", 4'b0010, 1'b1, 8'h40, 1'b1, 2'd1);
        tick();
        applyStimulus(4'b0010, 32'h0000_4000, 1'b0);
        checkOutput("t3 full again", 4'b0000, 1'b0, 8'h00, 1'b1, 2'd1);
        tick();
        drainFifo();
        doReset();

        // Test 4: requester 3 drops after 2 words, requester 0 waiting.
        applyStimulus(4'b1000, 32'h3300_0030, 1'b0);
        checkOutput("t4 bubble", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        tick();
        for (int w = 0; w < 2; w++) begin
            applyStimulus(4'b1001, 32'h3300_0030, 1'b0);
            checkOutput("t4 word", 4'b1000, 1'b1, 8'h33, 1'b1, 2'd3);
            tick();
        end
        applyStimulus(4'b0001, 32'h3300_0030, 1'b0);
        checkOutput("t4 drop", 4'b0000, 1'b0, 8'h00, 1'b1, 2'd3);
        tick();
        applyStimulus(4'b0001, 32'h3300_0030, 1'b0);
        checkOutput("t4 bubble2", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd3);
        tick();
        applyStimulus(4'b0001, 32'h3300_0030, 1'b0);
        checkOutput("t4 wrap grant", 4'b0001, 1'b1, 8'h30, 1'b1, 2'd0);
        tick();
        applyStimulus(4'b0000, 32'h0, 1'b0);
        checkOutput("t4 release", 4'b0000, 1'b0, 8'h00, 1'b1, 2'd0);
        tick();

        // Test 5: reset after word 2 of a burst by requester 2 (rr_ptr is 1).
        applyStimulus(4'b0100, 32'h0055_0000, 1'b0);
        checkOutput("t5 bubble", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        tick();
        for (int w = 0; w < 2; w++) begin
            applyStimulus(4'b0100, 32'h0055_0000, 1'b0);
            checkOutput("t5 word", 4'b0100, 1'b1, 8'h55, 1'b1, 2'd2);
            tick();
        end
        rst = 1'b1;
        applyStimulus(4'b0100, 32'h0055_0000, 1'b0);
        tick();
        rst = 1'b0;
        applyStimulus(4'b0101, 32'h0055_0050, 1'b0);
        checkOutput("t5 after reset", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        tick();
        applyStimulus(4'b0101, 32'h0055_0050, 1'b0);
        checkOutput("t5 restart from 0", 4'b0001, 1'b1, 8'h50, 1'b1, 2'd0);
        tick();
        applyStimulus(4'b0000, 32'h0, 1'b0);
        checkOutput("t5 release", 4'b0000, 1'b0, 8'h00, 1'b1, 2'd0);
        tick();
        drainFifo();
        doReset();

        // Test 6: three requesters all high, grants 0,1,2,0.
        req6     = 3'b111;
        reqData6 = 24'h22_21_20;
        for (int c = 0; c < 17; c++) begin
            #1;
            checks++;
            assert ($onehot0(ack6)) else begin
                errors++;
                $error("FAIL t6 ack onehot0 actual=%b required=onehot0", ack6);
            end
            checks++;
            assert (wr6 === (|ack6)) else begin
                errors++;
                $error("FAIL t6 wr_vs_ack actual=%b required=%b", wr6, |ack6);
            end
            checks++;
            assert (!(wr6 && full6)) else begin
                errors++;
                $error("FAIL t6 wr_when_full actual=1 required=0");
            end
            checks++;
            assert (busy6 === ((c % 5) != 0)) else begin
                errors++;
                $error("FAIL t6 busy cycle %0d actual=%b required=%b", c, busy6, (c % 5) != 0);
            end
            if ((c % 5) == 1) begin
                checks++;
                assert (gid6 === 2'(t6Order[c / 5])) else begin
                    errors++;
                    $error("FAIL t6 grant_id cycle %0d actual=%0d required=%0d",
                           c, gid6, t6Order[c / 5]);
                end
                checks++;
                assert (din6 === 8'(8'h20 + t6Order[c / 5])) else begin
                    errors++;
                    $error("FAIL t6 din cycle %0d actual=%h required=%h",
                           c, din6, 8'(8'h20 + t6Order[c / 5]));
                end
            end
            tick();
        end
        req6 = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
